// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage plus MEM/WB pipeline register.
// Loads and stores go to an internal word-addressed data memory with a fixed
// access latency. Upstream is stalled while an access is in flight. Results
// are presented as the registered rb_* / dm_Memory_out_Data bundle for writeback.
// Optional feature macro: MEM_ALIGN_CHECK_EN adds the align_err port and turns
// misaligned memory ops into single-cycle non-accessing completions.
module mem_access_stage #(
  parameter int d_size  = 32,
  parameter int ad_size = 32,
  parameter int DEPTH   = 256,
  parameter int LAT     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [d_size-1:0] ex_result,
  input  logic [d_size-1:0] ex_store_data,
  input  logic              ex_memread,
  input  logic              ex_memwrite,
  input  logic              ex_memtoreg,
  input  logic              ex_regwrite,
  output logic              mem_stall,
  output logic              rb_valid,
  output logic [d_size-1:0] rb_result,
  output logic [d_size-1:0] dm_Memory_out_Data,
  output logic              rb_memread,
  output logic              rb_memtoreg,
  output logic              rb_regwrite
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              align_err
`endif
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state, next_state;
  logic [CNTW-1:0]   cnt, next_cnt;

  logic [d_size-1:0] res_q;
  logic [d_size-1:0] data_q;
  logic              rd_q, wr_q, mtr_q, rw_q;

  logic [d_size-1:0] mem [DEPTH];

  logic              mem_op;
  logic              misaligned;
  logic              start;
  logic              done;
  logic [ad_size-1:0] byte_addr;
  logic [IDXW-1:0]   idx;
  logic              unused_addr;

  assign mem_op = ex_memread | ex_memwrite;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = (ex_result[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign start = (state == IDLE) & ex_valid & mem_op & ~misaligned;
  assign done  = (state == BUSY) & (cnt == '0);

  // The access always uses the captured address, so wrap is modulo DEPTH words.
  assign byte_addr   = res_q[ad_size-1:0];
  assign idx         = byte_addr[IDXW+1:2];
  assign unused_addr = ^{byte_addr[ad_size-1:IDXW+2], byte_addr[1:0]};

  // State and latency counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  // Next state: a memory op occupies BUSY for LAT edges, counting down to 0.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = BUSY;
          next_cnt   = CNTW'(LAT - 1);
        end
      end
      BUSY: begin
        if (done) next_state = IDLE;
        else      next_cnt   = cnt - CNTW'(1);
      end
      default: next_state = IDLE;
    endcase
  end

  // Stall is released in the final BUSY cycle so EX can advance on the completion edge.
  always_comb begin
    mem_stall = ex_valid & mem_op & ~misaligned & ~done;
  end

  // Request capture and MEM/WB output register; bubbles clear valid/regwrite only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rb_valid           <= 1'b0;
      rb_result          <= '0;
      dm_Memory_out_Data <= '0;
      rb_memread         <= 1'b0;
      rb_memtoreg        <= 1'b0;
      rb_regwrite        <= 1'b0;
      res_q              <= '0;
      data_q             <= '0;
      rd_q               <= 1'b0;
      wr_q               <= 1'b0;
      mtr_q              <= 1'b0;
      rw_q               <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      align_err          <= 1'b0;
`endif
    end else begin
      rb_valid    <= 1'b0;
      rb_regwrite <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      align_err   <= 1'b0;
`endif
      if (done) begin
        rb_valid    <= 1'b1;
        rb_result   <= res_q;
        rb_memread  <= rd_q;
        rb_memtoreg <= mtr_q;
        rb_regwrite <= rw_q;
        if (rd_q) dm_Memory_out_Data <= mem[idx];
      end else if ((state == IDLE) && ex_valid) begin
        if (!mem_op) begin
          rb_valid    <= 1'b1;
          rb_result   <= ex_result;
          rb_memread  <= ex_memread;
          rb_memtoreg <= ex_memtoreg;
          rb_regwrite <= ex_regwrite;
        end
`ifdef MEM_ALIGN_CHECK_EN
        else if (misaligned) begin
          rb_valid    <= 1'b1;
          rb_result   <= ex_result;
          rb_memread  <= 1'b0;
          rb_memtoreg <= ex_memtoreg;
          rb_regwrite <= 1'b0;
          align_err   <= 1'b1;
        end
`endif
        else begin
          res_q  <= ex_result;
          data_q <= ex_store_data;
          rd_q   <= ex_memread;
          wr_q   <= ex_memwrite;
          mtr_q  <= ex_memtoreg;
          rw_q   <= ex_regwrite;
        end
      end
    end
  end

  // Data memory write port; contents survive reset and stores land only on completion.
  always_ff @(posedge clk) begin
    if (done && wr_q) mem[idx] <= data_q;
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed vector bench for mem_access_stage.
// Main instance uses LAT=2; a second instance with LAT=1 covers back-to-back timing.
module tb_mem_access_stage;

  localparam int LAT_A = 2;

  logic        clk, rst;
  logic        ex_valid, ex_valid_b;
  logic [31:0] ex_result, ex_store_data;
  logic        ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite;

  logic        mem_stall, rb_valid, rb_memread, rb_memtoreg, rb_regwrite;
  logic [31:0] rb_result, dm_out;
  logic        mem_stall_b, rb_valid_b, rb_memread_b, rb_memtoreg_b, rb_regwrite_b;
  logic [31:0] rb_result_b, dm_out_b;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err, align_err_b;
`endif

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.d_size(32), .ad_size(32), .DEPTH(256), .LAT(LAT_A)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .mem_stall(mem_stall),
    .rb_valid(rb_valid), .rb_result(rb_result), .dm_Memory_out_Data(dm_out),
    .rb_memread(rb_memread), .rb_memtoreg(rb_memtoreg), .rb_regwrite(rb_regwrite)
`ifdef MEM_ALIGN_CHECK_EN
    , .align_err(align_err)
`endif
  );

  mem_access_stage #(.d_size(32), .ad_size(32), .DEPTH(256), .LAT(1)) dut_b (
    .clk(clk), .rst(rst), .ex_valid(ex_valid_b), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite), .mem_stall(mem_stall_b),
    .rb_valid(rb_valid_b), .rb_result(rb_result_b), .dm_Memory_out_Data(dm_out_b),
    .rb_memread(rb_memread_b), .rb_memtoreg(rb_memtoreg_b), .rb_regwrite(rb_regwrite_b)
`ifdef MEM_ALIGN_CHECK_EN
    , .align_err(align_err_b)
`endif
  );

  typedef struct {
    logic        rd, wr, mtr, rw;
    logic [31:0] res, sdata;
    logic [31:0] exp_res, exp_dm;
    logic        exp_rd, exp_rw;
  } vec_t;

  vec_t vecs[10];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rd, input logic wr, input logic mtr, input logic rw,
                              input logic [31:0] res, input logic [31:0] sdata,
                              input logic [31:0] exp_dm, input logic exp_rd, input logic exp_rw);
    vec_t v;
    v.rd = rd; v.wr = wr; v.mtr = mtr; v.rw = rw;
    v.res = res; v.sdata = sdata;
    v.exp_res = res; v.exp_dm = exp_dm;
    v.exp_rd = exp_rd; v.exp_rw = exp_rw;
    return v;
  endfunction

  // Compare one observed value against its expected value
  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Present one instruction on the EX bundle of the main instance
  task automatic apply_stimulus(input vec_t v);
    ex_valid      = 1'b1;
    ex_result     = v.res;
    ex_store_data = v.sdata;
    ex_memread    = v.rd;
    ex_memwrite   = v.wr;
    ex_memtoreg   = v.mtr;
    ex_regwrite   = v.rw;
  endtask

  // Hold one instruction through its stall window and check the completed bundle
  task automatic run_op(input vec_t v, input string tag);
    int n;
    apply_stimulus(v);
    n = (v.rd || v.wr) ? LAT_A + 1 : 1;
    for (int c = 0; c < n; c++) begin
      #1;
      check_output({tag, "_stall"}, {31'b0, mem_stall}, {31'b0, (c < n - 1)});
      @(posedge clk);
      #1;
      if (c < n - 1) begin
        check_output({tag, "_busy_valid"}, {31'b0, rb_valid}, 32'd0);
      end else begin
        check_output({tag, "_valid"},    {31'b0, rb_valid},    32'd1);
        check_output({tag, "_result"},   rb_result,            v.exp_res);
        check_output({tag, "_dm"},       dm_out,               v.exp_dm);
        check_output({tag, "_memread"},  {31'b0, rb_memread},  {31'b0, v.exp_rd});
        check_output({tag, "_regwrite"}, {31'b0, rb_regwrite}, {31'b0, v.exp_rw});
      end
    end
  endtask

  initial begin
    rst = 1'b0;
    ex_valid = 1'b0; ex_valid_b = 1'b0;
    ex_result = '0; ex_store_data = '0;
    ex_memread = 1'b0; ex_memwrite = 1'b0; ex_memtoreg = 1'b0; ex_regwrite = 1'b0;

    //           rd wr mtr rw  res           sdata         exp_dm        erd erw
    vecs[0] = mk(0, 0, 0, 1, 32'h0000_1234, 32'h0,        32'h0,        0, 1);
    vecs[1] = mk(0, 1, 0, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,       0, 0);
    vecs[2] = mk(1, 0, 1, 1, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1, 1);
    vecs[3] = mk(0, 1, 0, 0, 32'h0000_0410, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 0, 0);
    vecs[4] = mk(1, 0, 1, 1, 32'h0000_0010, 32'h0,        32'hA5A5_A5A5, 1, 1);
    vecs[5] = mk(0, 1, 0, 0, 32'h0000_0030, 32'h0000_0005, 32'hA5A5_A5A5, 0, 0);
    vecs[6] = mk(1, 1, 1, 1, 32'h0000_0030, 32'h0000_0009, 32'h0000_0005, 1, 1);
    vecs[7] = mk(1, 0, 1, 1, 32'h0000_0030, 32'h0,        32'h0000_0009, 1, 1);
    vecs[8] = mk(0, 0, 0, 0, 32'hFFFF_FFFF, 32'h0,        32'h0000_0009, 0, 0);
    vecs[9] = mk(0, 1, 0, 0, 32'h0000_0020, 32'h0,        32'h0000_0009, 0, 0);

    #12;
    check_output("reset_valid",  {31'b0, rb_valid}, 32'd0);
    check_output("reset_result", rb_result,         32'd0);
    check_output("reset_dm",     dm_out,            32'd0);
    check_output("reset_stall",  {31'b0, mem_stall}, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    ex_valid = 1'b0;
    #1;
    check_output("bubble_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk);
    #1;
    check_output("bubble_valid",    {31'b0, rb_valid},    32'd0);
    check_output("bubble_regwrite", {31'b0, rb_regwrite}, 32'd0);
    check_output("bubble_result",   rb_result,            32'h0000_0020);
    check_output("bubble_dm",       dm_out,               32'h0000_0009);

    // Reset in the middle of a BUSY store must discard the store
    apply_stimulus(mk(0, 1, 0, 1, 32'h0000_0020, 32'h1111_1111, 32'h0, 0, 0));
    #1;
    check_output("rstbusy_stall0", {31'b0, mem_stall}, 32'd1);
    @(posedge clk);
    #1;
    check_output("rstbusy_stall1", {31'b0, mem_stall}, 32'd1);
    rst = 1'b0;
    #1;
    check_output("rstbusy_result", rb_result,         32'd0);
    check_output("rstbusy_dm",     dm_out,            32'd0);
    check_output("rstbusy_valid",  {31'b0, rb_valid}, 32'd0);
    ex_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(mk(1, 0, 1, 1, 32'h0000_0020, 32'h0, 32'h0, 1, 1), "rstbusy_load");
    ex_valid = 1'b0;

    // LAT=1 instance: two identical loads back to back
    ex_result = 32'h0000_0010; ex_memread = 1'b1; ex_memwrite = 1'b0;
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1;
    ex_valid_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_output($sformatf("lat1_stall%0d", i), {31'b0, mem_stall_b}, {31'b0, (i % 2 == 0)});
      @(posedge clk);
      #1;
      check_output($sformatf("lat1_valid%0d", i), {31'b0, rb_valid_b}, {31'b0, (i % 2 == 1)});
    end
    ex_valid_b = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned ops complete at once without touching memory
    apply_stimulus(mk(1, 0, 1, 1, 32'h0000_0012, 32'h0, 32'h0, 0, 0));
    #1;
    check_output("align_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk);
    #1;
    check_output("align_err",      {31'b0, align_err},   32'd1);
    check_output("align_valid",    {31'b0, rb_valid},    32'd1);
    check_output("align_regwrite", {31'b0, rb_regwrite}, 32'd0);
    check_output("align_memread",  {31'b0, rb_memread},  32'd0);
    apply_stimulus(mk(0, 1, 0, 1, 32'h0000_0012, 32'h0000_0077, 32'h0, 0, 0));
    #1;
    check_output("align_st_stall", {31'b0, mem_stall}, 32'd0);
    @(posedge clk);
    #1;
    check_output("align_st_err", {31'b0, align_err}, 32'd1);
    ex_valid = 1'b0;
    @(posedge clk);
    #1;
    check_output("align_err_clear", {31'b0, align_err}, 32'd0);
    run_op(mk(1, 0, 1, 1, 32'h0000_0010, 32'h0, 32'hA5A5_A5A5, 1, 1), "align_untouched");
    ex_valid = 1'b0;
`endif

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
